// File: rtl/prbs_stream_gen_pkg.sv
// Shared types and helpers for the PRBS measurement-matrix stream generator.
// The n-step LFSR advance lives here so the core and any future consumers agree on bit order.
package prbs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int          PRBS_MAX_W = 32;
    localparam int          PRBS_IDX_W = $clog2(PRBS_MAX_W);
    localparam int          DEF_LFSR_W = 11;
    localparam logic [10:0] DEF_TAPS   = 11'h500;
    localparam logic [10:0] DEF_SEED   = 11'h7FF;

    typedef struct packed {
        logic [PRBS_MAX_W-1:0] state;
        logic [PRBS_MAX_W-1:0] bits;
    } lfsr_step_t;

    // Fibonacci LFSR advanced n times; bits[k] is the MSB seen before step k.
    function automatic lfsr_step_t lfsr_step_n(
        input logic [PRBS_MAX_W-1:0] state,
        input logic [PRBS_MAX_W-1:0] taps,
        input int unsigned           width,
        input int unsigned           n
    );
        lfsr_step_t            res;
        logic [PRBS_MAX_W-1:0] s;
        logic [PRBS_MAX_W-1:0] mask;
        logic                  fb;
        mask = {PRBS_MAX_W{1'b1}} >> (PRBS_MAX_W - width);
        s    = state & mask;
        res  = '0;
        fb   = 1'b0;
        for (int k = 0; k < PRBS_MAX_W; k++) begin
            if (k < int'(n)) begin
                res.bits[PRBS_IDX_W'(k)] = s[PRBS_IDX_W'(width - 1)];
                fb = ^(s & taps);
                s  = {s[PRBS_MAX_W-2:0], fb} & mask;
            end
        end
        res.state = s;
        return res;
    endfunction

endpackage

// File: rtl/prbs_stream_gen_if.sv
// Output stream bundle: one PRBS word per beat with row framing.
interface prbs_stream_gen_if #(
    parameter int OUT_BITS = 8,
    parameter int ROW_W    = 4
) ();
    logic                out_valid;
    logic                out_ready;
    logic [OUT_BITS-1:0] out_data;
    logic                out_last;
    logic [ROW_W-1:0]    row_idx;

    modport master (output out_valid, out_data, out_last, row_idx, input out_ready);
    modport slave  (input out_valid, out_data, out_last, row_idx, output out_ready);
endinterface

// File: rtl/prbs_stream_gen_lfsr_core.sv
// LFSR register with seed load (zero seed replaced by the default) and an
// OUT_BITS-step unrolled advance; the output word is decoded from the register alone.
module prbs_lfsr_core
    import prbs_pkg::*;
#(
    parameter int                LFSR_W       = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS         = DEF_TAPS,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = DEF_SEED,
    parameter int                OUT_BITS     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [LFSR_W-1:0]   seed_i,
    input  logic                advance_i,
    output logic [OUT_BITS-1:0] word_o
);

    lfsr_step_t        step;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] seed_eff;
    logic              unused_step;

    always_comb begin
        step = lfsr_step_n(PRBS_MAX_W'(lfsr_q), PRBS_MAX_W'(TAPS), LFSR_W, OUT_BITS);
    end

    assign lfsr_d      = step.state[LFSR_W-1:0];
    assign word_o      = step.bits[OUT_BITS-1:0];
    assign unused_step = ^step;
    // An all-zero state would lock the LFSR, so substitute the default seed.
    assign seed_eff    = (seed_i == '0) ? DEFAULT_SEED : seed_i;

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q <= DEFAULT_SEED;
        end else if (load_i) begin
            lfsr_q <= seed_eff;
        end else if (advance_i) begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/prbs_stream_gen.sv
// Streams the compressed-sensing measurement matrix row by row as OUT_BITS-wide
// PRBS words with valid/ready backpressure, row framing and one-shot/continuous modes.
module prbs_stream_gen
    import prbs_pkg::*;
#(
    parameter int                LFSR_W       = 11,
    parameter logic [LFSR_W-1:0] TAPS         = 11'h500,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 11'h7FF,
    parameter int                OUT_BITS     = 8,
    parameter int                ROW_LEN      = 2048,
    parameter int                NUM_ROWS     = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cont,
    input  logic              stop,
    input  logic [LFSR_W-1:0] seed_in,
    prbs_stream_gen_if.master out_if,
    output logic              busy,
    output logic              done
);

    localparam int BEATS_PER_ROW = ROW_LEN / OUT_BITS;
    localparam int BEAT_W        = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
    localparam int ROW_W         = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    state_e             state_q;
    logic [BEAT_W-1:0]  beat_q;
    logic [ROW_W-1:0]   row_q;
    logic               cont_q;
    logic               valid_q;
    logic               last_q;
    logic               busy_q;
    logic               done_q;
    logic               start_ok;
    logic               handshake;

    // stop outranks start in DONE; start is ignored in RUN.
    assign start_ok  = start && ((state_q == IDLE) || ((state_q == DONE) && !stop));
    assign handshake = (state_q == RUN) && !stop && valid_q && out_if.out_ready;

    prbs_lfsr_core #(
        .LFSR_W       (LFSR_W),
        .TAPS         (TAPS),
        .DEFAULT_SEED (DEFAULT_SEED),
        .OUT_BITS     (OUT_BITS)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load_i    (start_ok),
        .seed_i    (seed_in),
        .advance_i (handshake),
        .word_o    (out_if.out_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            row_q   <= '0;
            cont_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (stop && state_q == DONE) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end else if (start_ok) begin
                        state_q <= RUN;
                        beat_q  <= '0;
                        row_q   <= '0;
                        cont_q  <= cont;
                        valid_q <= 1'b1;
                        last_q  <= (BEATS_PER_ROW == 1);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (handshake) begin
                        if (last_q) begin
                            beat_q <= '0;
                            last_q <= (BEATS_PER_ROW == 1);
                            if (int'(row_q) == NUM_ROWS - 1) begin
                                row_q <= '0;
                                if (!cont_q) begin
                                    state_q <= DONE;
                                    valid_q <= 1'b0;
                                    last_q  <= 1'b0;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            beat_q <= beat_q + 1'b1;
                            last_q <= (int'(beat_q) == BEATS_PER_ROW - 2);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_last  = last_q;
    assign out_if.row_idx   = row_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_prbs_stream_gen.sv
// Scoreboard bench: expected beats come from a bit-recurrence model of the PRBS;
// a negedge monitor pops and compares on every accepted beat.
module tb_prbs_stream_gen;

    localparam int          LFSR_W      = 11;
    localparam int          OUT_BITS    = 8;
    localparam int          ROW_LEN     = 2048;
    localparam int          NUM_ROWS    = 12;
    localparam int          BPR         = ROW_LEN / OUT_BITS;
    localparam int          ROW_W       = 4;
    localparam int          FRAME_BEATS = BPR * NUM_ROWS;
    localparam logic [10:0] TAPS        = 11'h500;
    localparam logic [10:0] DSEED       = 11'h7FF;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              cont = 1'b0;
    logic              stop = 1'b0;
    logic [LFSR_W-1:0] seed_in = '0;
    logic              busy;
    logic              done;

    prbs_stream_gen_if #(.OUT_BITS(OUT_BITS), .ROW_W(ROW_W)) sif ();

    prbs_stream_gen #(
        .LFSR_W       (LFSR_W),
        .TAPS         (TAPS),
        .DEFAULT_SEED (DSEED),
        .OUT_BITS     (OUT_BITS),
        .ROW_LEN      (ROW_LEN),
        .NUM_ROWS     (NUM_ROWS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cont    (cont),
        .stop    (stop),
        .seed_in (seed_in),
        .out_if  (sif),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [3:0] row;
    } beat_t;

    beat_t exp_q[$];
    bit    cap_bits[$];
    int    checks = 0;
    int    failures = 0;
    int    acc_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output bit j obeys o[j] = XOR over taps i of o[j-1-i]; the first LFSR_W bits are the seed MSB-first.
    task automatic push_stream(input logic [10:0] seed, input int nbeats);
        bit          bits[];
        logic [10:0] s;
        logic [10:0] tp;
        bit          x;
        beat_t       b;
        s    = (seed == '0) ? DSEED : seed;
        tp   = TAPS;
        bits = new[nbeats * OUT_BITS];
        for (int j = 0; j < bits.size(); j++) begin
            if (j < LFSR_W) begin
                bits[j] = s[LFSR_W-1-j];
            end else begin
                x = 1'b0;
                for (int i = 0; i < LFSR_W; i++)
                    if (tp[i]) x ^= bits[j-1-i];
                bits[j] = x;
            end
        end
        for (int bi = 0; bi < nbeats; bi++) begin
            for (int k = 0; k < OUT_BITS; k++) b.data[k] = bits[bi*OUT_BITS + k];
            b.last = ((bi % BPR) == BPR - 1);
            b.row  = 4'((bi / BPR) % NUM_ROWS);
            exp_q.push_back(b);
        end
    endtask

    // Monitor: compare each accepted beat, and check stalled outputs hold steady.
    beat_t      mon_e;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [3:0] prev_row;
    bit         prev_stall = 1'b0;

    always @(negedge clk) begin
        if (sif.out_valid === 1'b1 && sif.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_beat: got beat 0x%0h expected no beat", sif.out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk($sformatf("beat%0d_data", acc_cnt), 32'(sif.out_data), 32'(mon_e.data));
                chk($sformatf("beat%0d_last", acc_cnt), 32'(sif.out_last), 32'(mon_e.last));
                chk($sformatf("beat%0d_row", acc_cnt), 32'(sif.row_idx), 32'(mon_e.row));
                for (int k = 0; k < OUT_BITS; k++) cap_bits.push_back(sif.out_data[k]);
                acc_cnt++;
            end
        end
        if (prev_stall && sif.out_valid === 1'b1) begin
            chk("stall_data", 32'(sif.out_data), 32'(prev_data));
            chk("stall_last", 32'(sif.out_last), 32'(prev_last));
            chk("stall_row", 32'(sif.row_idx), 32'(prev_row));
        end
        prev_stall = (sif.out_valid === 1'b1) && (sif.out_ready !== 1'b1);
        prev_data  = sif.out_data;
        prev_last  = sif.out_last;
        prev_row   = sif.row_idx;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ready(input bit rnd);
        sif.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    task automatic do_start(input logic [10:0] seed, input logic mode);
        seed_in = seed;
        cont    = mode;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
        cont    = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int limit, input bit rnd, input string name);
        int c = 0;
        while (acc_cnt < n && c < limit) begin
            drive_ready(rnd);
            cyc();
            c++;
        end
        chk(name, 32'(acc_cnt >= n), 32'd1);
    endtask

    task automatic wait_done(input int limit, input bit rnd, input string name);
        int c = 0;
        while (done !== 1'b1 && c < limit) begin
            drive_ready(rnd);
            cyc();
            c++;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic check_frame_end(input string tag);
        chk({tag, "_valid_low"}, 32'(sif.out_valid), 32'd0);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_beats"}, 32'(acc_cnt), 32'(FRAME_BEATS));
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    int          ones;
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [10:0] rseed;

    initial begin
        sif.out_ready = 1'b0;
        repeat (3) cyc();
        chk("rst_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_last", 32'(sif.out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_row", 32'(sif.row_idx), 32'd0);
        reset = 1'b1;
        cyc();

        // One frame from seed 0x7FF, never stalled.
        acc_cnt = 0;
        cap_bits.delete();
        push_stream(11'h7FF, FRAME_BEATS);
        sif.out_ready = 1'b1;
        do_start(11'h7FF, 1'b0);
        chk("start_latency_valid", 32'(sif.out_valid), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        wait_done(FRAME_BEATS + 100, 1'b0, "frame_a_done");
        check_frame_end("frame_a");
        if (cap_bits.size() >= 2048) begin
            ones = 0;
            for (int i = 0; i < 2047; i++) ones += int'(cap_bits[i]);
            chk("ones_in_period", 32'(ones), 32'd1024);
            chk("period_wrap_bit", 32'(cap_bits[2047]), 32'(cap_bits[0]));
            for (int k = 0; k < 8; k++) begin
                w0[k] = cap_bits[k];
                w1[k] = cap_bits[8 + k];
            end
            chk("first_word", 32'(w0), 32'h0FF);
            chk("second_word", 32'(w1), 32'h007);
        end else begin
            chk("captured_bits", 32'(cap_bits.size()), 32'd2048);
        end

        // Zero seed under random backpressure, with a start pulse while busy.
        acc_cnt = 0;
        cap_bits.delete();
        push_stream(11'h000, FRAME_BEATS);
        do_start(11'h000, 1'b0);
        wait_acc(1000, 4000, 1'b1, "frame_b_progress");
        chk("busy_before_restart", 32'(busy), 32'd1);
        seed_in = 11'h123;
        cont    = 1'b1;
        start   = 1'b1;
        drive_ready(1'b1);
        cyc();
        start = 1'b0;
        cont  = 1'b0;
        wait_done(10000, 1'b1, "frame_b_done");
        check_frame_end("frame_b");

        // Continuous mode past the row wrap, then stop.
        acc_cnt = 0;
        rseed = 11'($urandom_range(1, 2047));
        push_stream(rseed, FRAME_BEATS + 2 * BPR);
        do_start(rseed, 1'b1);
        for (int c = 0; c < 12000 && acc_cnt < FRAME_BEATS + 64; c++) begin
            drive_ready(1'b1);
            cyc();
            chk("cont_valid", 32'(sif.out_valid), 32'd1);
            chk("cont_done", 32'(done), 32'd0);
        end
        chk("cont_progress", 32'(acc_cnt >= FRAME_BEATS + 64), 32'd1);
        sif.out_ready = 1'b0;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_valid", 32'(sif.out_valid), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        exp_q.delete();

        // Reset mid-row, then the same seed must restart from its first word.
        acc_cnt = 0;
        rseed = 11'($urandom_range(1, 2047));
        push_stream(rseed, FRAME_BEATS);
        sif.out_ready = 1'b1;
        do_start(rseed, 1'b0);
        wait_acc(100, 400, 1'b0, "pre_reset_progress");
        sif.out_ready = 1'b0;
        reset = 1'b0;
        cyc();
        chk("midrst_valid", 32'(sif.out_valid), 32'd0);
        chk("midrst_last", 32'(sif.out_last), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_row", 32'(sif.row_idx), 32'd0);
        reset = 1'b1;
        cyc();
        exp_q.delete();
        acc_cnt = 0;
        push_stream(rseed, 8);
        sif.out_ready = 1'b1;
        do_start(rseed, 1'b0);
        wait_acc(4, 100, 1'b0, "post_reset_progress");
        sif.out_ready = 1'b0;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        exp_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
